// File: rtl/mux_pkg.sv
// Shared helpers for the N-way select blocks.
// Select-width derivation used by the selector and the skid wrapper.
package mux_pkg;

    function automatic int sel_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mux_n_sel.sv
// Combinational N-way lane select with range check.
// Out-of-range indices fall back to DEFAULT_SEL and raise err.
module mux_n_sel
    import mux_pkg::*;
#(
    parameter int DATA_W      = 16,
    parameter int N_IN        = 4,
    parameter int DEFAULT_SEL = 0,
    localparam int SEL_W      = sel_width(N_IN)
) (
    input  logic [N_IN*DATA_W-1:0] in_data,
    input  logic [SEL_W-1:0]       in_sel,
    output logic [DATA_W-1:0]      data,
    output logic [SEL_W-1:0]       sel_used,
    output logic                   err
);

    logic [31:0] w_idx;

    assign w_idx    = 32'(in_sel);
    assign err      = (w_idx >= 32'(N_IN));
    assign sel_used = err ? SEL_W'(DEFAULT_SEL) : in_sel;

    always_comb begin
        data = '0;
        for (int k = 0; k < N_IN; k++) begin
            if (sel_used == SEL_W'(k)) begin
                data = in_data[k*DATA_W +: DATA_W];
            end
        end
    end

endmodule

// File: rtl/mux_n_skid.sv
// N-way lane select feeding a 2-entry skid buffer.
// in_ready is a flop, so no combinational path from out_ready.
module mux_n_skid
    import mux_pkg::*;
#(
    parameter int DATA_W      = 16,
    parameter int N_IN        = 4,
    parameter int DEFAULT_SEL = 0,
    localparam int SEL_W      = sel_width(N_IN)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_IN*DATA_W-1:0] in_data,
    input  logic [SEL_W-1:0]       in_sel,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   flush,
    output logic [DATA_W-1:0]      out_data,
    output logic [SEL_W-1:0]       out_sel,
    output logic                   out_sel_err,
    output logic                   out_valid,
    input  logic                   out_ready
);

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [SEL_W-1:0]  sel;
        logic              err;
    } entry_t;

    entry_t r_m;
    entry_t r_s;
    logic   r_m_vld;
    logic   r_s_vld;
    logic   r_in_ready;

    entry_t w_new;
    entry_t w_m_nxt;
    entry_t w_s_nxt;
    logic   w_m_vld_nxt;
    logic   w_s_vld_nxt;
    logic   w_acc;
    logic   w_emit;

    mux_n_sel #(
        .DATA_W      (DATA_W),
        .N_IN        (N_IN),
        .DEFAULT_SEL (DEFAULT_SEL)
    ) u_sel (
        .in_data  (in_data),
        .in_sel   (in_sel),
        .data     (w_new.data),
        .sel_used (w_new.sel),
        .err      (w_new.err)
    );

    assign w_acc  = in_valid && r_in_ready;
    assign w_emit = r_m_vld && out_ready;

    // S only ever fills while M is held, so S.valid implies M.valid
    always_comb begin
        w_m_nxt     = r_m;
        w_s_nxt     = r_s;
        w_m_vld_nxt = r_m_vld;
        w_s_vld_nxt = r_s_vld;
        if (flush) begin
            w_m_vld_nxt = 1'b0;
            w_s_vld_nxt = 1'b0;
        end else if (w_emit && r_s_vld) begin
            w_m_nxt     = r_s;
            w_s_vld_nxt = 1'b0;
        end else if (w_acc && (!r_m_vld || w_emit)) begin
            w_m_nxt     = w_new;
            w_m_vld_nxt = 1'b1;
        end else if (w_acc) begin
            w_s_nxt     = w_new;
            w_s_vld_nxt = 1'b1;
        end else if (w_emit) begin
            w_m_vld_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_m        <= '0;
            r_s        <= '0;
            r_m_vld    <= 1'b0;
            r_s_vld    <= 1'b0;
            r_in_ready <= 1'b1;
        end else begin
            r_m        <= w_m_nxt;
            r_s        <= w_s_nxt;
            r_m_vld    <= w_m_vld_nxt;
            r_s_vld    <= w_s_vld_nxt;
            r_in_ready <= !w_s_vld_nxt;
        end
    end

    assign in_ready    = r_in_ready;
    assign out_valid   = r_m_vld;
    assign out_data    = r_m.data;
    assign out_sel     = r_m.sel;
    assign out_sel_err = r_m.err;

endmodule

// File: tb/tb_mux_n_skid.sv
// Directed bench for mux_n_skid: vector table plus
// hand-written reset, out-of-range and mid-stream reset cases.
module tb_mux_n_skid;

    logic        clk = 1'b0;
    logic        rst;

    logic [63:0] in_data;
    logic [1:0]  in_sel;
    logic        in_valid;
    logic        in_ready;
    logic        flush;
    logic [15:0] out_data;
    logic [1:0]  out_sel;
    logic        out_sel_err;
    logic        out_valid;
    logic        out_ready;

    logic [47:0] in3_data;
    logic [1:0]  in3_sel;
    logic        in3_valid;
    logic        in3_ready;
    logic        flush3;
    logic [15:0] out3_data;
    logic [1:0]  out3_sel;
    logic        out3_err;
    logic        out3_valid;
    logic        out3_ready;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    mux_n_skid #(.DATA_W(16), .N_IN(4), .DEFAULT_SEL(0)) u_dut (
        .clk         (clk),
        .rst         (rst),
        .in_data     (in_data),
        .in_sel      (in_sel),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .flush       (flush),
        .out_data    (out_data),
        .out_sel     (out_sel),
        .out_sel_err (out_sel_err),
        .out_valid   (out_valid),
        .out_ready   (out_ready)
    );

    mux_n_skid #(.DATA_W(16), .N_IN(3), .DEFAULT_SEL(1)) u_dut3 (
        .clk         (clk),
        .rst         (rst),
        .in_data     (in3_data),
        .in_sel      (in3_sel),
        .in_valid    (in3_valid),
        .in_ready    (in3_ready),
        .flush       (flush3),
        .out_data    (out3_data),
        .out_sel     (out3_sel),
        .out_sel_err (out3_err),
        .out_valid   (out3_valid),
        .out_ready   (out3_ready)
    );

    typedef struct {
        logic        vld;
        logic [1:0]  sel;
        logic        ordy;
        logic        fl;
        logic        e_ov;
        logic        e_ir;
        logic [15:0] e_d;
        logic [1:0]  e_s;
    } vec_t;

    vec_t tbl[21];

    function automatic vec_t mk(input logic vld, input logic [1:0] sel,
                                input logic ordy, input logic fl,
                                input logic e_ov, input logic e_ir,
                                input logic [15:0] e_d,
                                input logic [1:0] e_s);
        vec_t v;
        v.vld  = vld;
        v.sel  = sel;
        v.ordy = ordy;
        v.fl   = fl;
        v.e_ov = e_ov;
        v.e_ir = e_ir;
        v.e_d  = e_d;
        v.e_s  = e_s;
        return v;
    endfunction

    task automatic chk(input string name, input int row,
                       input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s row %0d: got %0h want %0h", name, row, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst        = 1'b1;
        in_data    = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
        in_sel     = 2'd0;
        in_valid   = 1'b1;
        flush      = 1'b0;
        out_ready  = 1'b0;
        in3_data   = {16'hC2C2, 16'hB1B1, 16'hA0A0};
        in3_sel    = 2'd0;
        in3_valid  = 1'b0;
        flush3     = 1'b0;
        out3_ready = 1'b0;

        // streaming
        tbl[0]  = mk(1'b1, 2'd0, 1'b1, 1'b0, 1'b1, 1'b1, 16'h1111, 2'd0);
        tbl[1]  = mk(1'b1, 2'd1, 1'b1, 1'b0, 1'b1, 1'b1, 16'h2222, 2'd1);
        tbl[2]  = mk(1'b1, 2'd2, 1'b1, 1'b0, 1'b1, 1'b1, 16'h3333, 2'd2);
        tbl[3]  = mk(1'b1, 2'd3, 1'b1, 1'b0, 1'b1, 1'b1, 16'h4444, 2'd3);
        tbl[4]  = mk(1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0000, 2'd0);
        // backpressure
        tbl[5]  = mk(1'b1, 2'd2, 1'b0, 1'b0, 1'b1, 1'b1, 16'h3333, 2'd2);
        tbl[6]  = mk(1'b1, 2'd1, 1'b0, 1'b0, 1'b1, 1'b0, 16'h3333, 2'd2);
        tbl[7]  = mk(1'b1, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h3333, 2'd2);
        tbl[8]  = mk(1'b1, 2'd0, 1'b1, 1'b0, 1'b1, 1'b1, 16'h2222, 2'd1);
        tbl[9]  = mk(1'b1, 2'd0, 1'b1, 1'b0, 1'b1, 1'b1, 16'h1111, 2'd0);
        tbl[10] = mk(1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0000, 2'd0);
        // flush with M and S full, then flush dropping a same-cycle beat
        tbl[11] = mk(1'b1, 2'd3, 1'b0, 1'b0, 1'b1, 1'b1, 16'h4444, 2'd3);
        tbl[12] = mk(1'b1, 2'd2, 1'b0, 1'b0, 1'b1, 1'b0, 16'h4444, 2'd3);
        tbl[13] = mk(1'b1, 2'd1, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0000, 2'd0);
        tbl[14] = mk(1'b1, 2'd1, 1'b0, 1'b0, 1'b1, 1'b1, 16'h2222, 2'd1);
        tbl[15] = mk(1'b1, 2'd0, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0000, 2'd0);
        tbl[16] = mk(1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0000, 2'd0);
        // simultaneous emit and accept: no bubble, S never fills
        tbl[17] = mk(1'b1, 2'd0, 1'b1, 1'b0, 1'b1, 1'b1, 16'h1111, 2'd0);
        tbl[18] = mk(1'b1, 2'd1, 1'b1, 1'b0, 1'b1, 1'b1, 16'h2222, 2'd1);
        tbl[19] = mk(1'b1, 2'd2, 1'b1, 1'b0, 1'b1, 1'b1, 16'h3333, 2'd2);
        tbl[20] = mk(1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0000, 2'd0);

        // reset held 2 cycles with in_valid high
        step();
        step();
        chk("rst_ovalid", 0, 32'(out_valid), 32'd0);
        chk("rst_iready", 0, 32'(in_ready), 32'd1);
        chk("rst_data", 0, 32'(out_data), 32'd0);
        chk("rst_sel", 0, 32'(out_sel), 32'd0);
        chk("rst_err", 0, 32'(out_sel_err), 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 21; i++) begin
            in_valid  = tbl[i].vld;
            in_sel    = tbl[i].sel;
            out_ready = tbl[i].ordy;
            flush     = tbl[i].fl;
            step();
            chk("ovalid", i, 32'(out_valid), 32'(tbl[i].e_ov));
            chk("iready", i, 32'(in_ready), 32'(tbl[i].e_ir));
            if (tbl[i].e_ov) begin
                chk("data", i, 32'(out_data), 32'(tbl[i].e_d));
                chk("sel", i, 32'(out_sel), 32'(tbl[i].e_s));
                chk("err", i, 32'(out_sel_err), 32'd0);
            end
        end

        // reset together with flush and accept while M is full
        in_valid  = 1'b1;
        in_sel    = 2'd3;
        out_ready = 1'b0;
        flush     = 1'b0;
        step();
        chk("pre_rst_data", 0, 32'(out_data), 32'h4444);
        rst   = 1'b1;
        flush = 1'b1;
        in_sel = 2'd2;
        step();
        chk("mid_rst_ovalid", 0, 32'(out_valid), 32'd0);
        chk("mid_rst_iready", 0, 32'(in_ready), 32'd1);
        chk("mid_rst_data", 0, 32'(out_data), 32'd0);
        chk("mid_rst_sel", 0, 32'(out_sel), 32'd0);
        chk("mid_rst_err", 0, 32'(out_sel_err), 32'd0);
        rst      = 1'b0;
        flush    = 1'b0;
        in_valid = 1'b0;

        // out-of-range index on the 3-lane instance
        in3_valid  = 1'b1;
        in3_sel    = 2'd3;
        out3_ready = 1'b1;
        step();
        chk("oor_valid", 0, 32'(out3_valid), 32'd1);
        chk("oor_data", 0, 32'(out3_data), 32'hB1B1);
        chk("oor_sel", 0, 32'(out3_sel), 32'd1);
        chk("oor_err", 0, 32'(out3_err), 32'd1);
        in3_sel = 2'd2;
        step();
        chk("inr_valid", 0, 32'(out3_valid), 32'd1);
        chk("inr_data", 0, 32'(out3_data), 32'hC2C2);
        chk("inr_sel", 0, 32'(out3_sel), 32'd2);
        chk("inr_err", 0, 32'(out3_err), 32'd0);
        in3_valid = 1'b0;
        step();
        chk("drain3_valid", 0, 32'(out3_valid), 32'd0);
        chk("drain3_iready", 0, 32'(in3_ready), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
